// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_ROR = 2'b00,
    SH_ROL = 2'b01,
    SH_SRL = 2'b10,
    SH_SRA = 2'b11
  } shift_mode_e;

  // Control fields carried alongside every stage's data. The data and amt
  // fields are width-dependent, so the top wraps this into its own stage_t.
  typedef struct packed {
    shift_mode_e mode;
    logic        sign;
    logic        valid;
  } stage_ctrl_t;

  // Shift-amount width, which is also the number of pipeline stages.
  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel-shifter stage: optionally shifts by DIST bits.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             sel_i,
  input  shift_mode_e      mode_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  // Select between passthrough and the four shift/rotate flavours.
  always_comb begin
    data_o = data_i;
    if (sel_i) begin
      case (mode_i)
        SH_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        SH_ROL:  data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
        SH_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        SH_SRA:  data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit,
// globally stalled by a single advance signal for full back-pressure.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    stage_ctrl_t      ctrl;
  } stage_t;

  logic             advance;
  stage_t           in_beat;
  stage_t           tail_q;
  logic [WIDTH-1:0] last_shifted;
  logic             zero_q;
  logic             unused_tail;

  // The pipe moves as a whole unless a held result is being refused.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Pack the input beat; the sign is frozen here so SRA never re-reads
  // a partially shifted MSB.
  always_comb begin
    in_beat.data       = in_data;
    in_beat.amt        = in_amt;
    in_beat.ctrl.mode  = shift_mode_e'(in_mode);
    in_beat.ctrl.sign  = in_data[WIDTH-1];
    in_beat.ctrl.valid = in_valid;
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    stage_t           src;
    stage_t           stage_d;
    stage_t           stage_q;
    logic [WIDTH-1:0] shifted;

    if (k == 0) begin : g_first
      assign src = in_beat;
    end else begin : g_next
      assign src = g_stage[k-1].stage_q;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_shift (
      .data_i (src.data),
      .sel_i  (src.amt[k]),
      .mode_i (src.ctrl.mode),
      .sign_i (src.ctrl.sign),
      .data_o (shifted)
    );

    // Next-state: everything travels unchanged except the shifted data.
    always_comb begin
      stage_d      = src;
      stage_d.data = shifted;
    end

    // Stage register, frozen while the output is stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else if (advance) begin
        stage_q <= stage_d;
      end
    end

    if (k == SHW - 1) begin : g_last
      assign last_shifted = shifted;
    end
  end

  assign tail_q = g_stage[SHW-1].stage_q;

  // Zero flag registered alongside the final stage so it adds no latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
    end else if (advance) begin
      zero_q <= (last_shifted == '0);
    end
  end

  assign out_valid = tail_q.ctrl.valid;
  assign out_data  = tail_q.data;
  assign out_zero  = zero_q;

  // Control fields of the last stage have no consumer downstream.
  assign unused_tail = ^{tail_q.amt, tail_q.ctrl.mode, tail_q.ctrl.sign};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8, latency 3).
module tb_pipelined_barrel_shifter;

  localparam int W = 8;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_amt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  // Reference: rotate via a doubled word, shifts via native operators.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a, input int m);
    logic [2*W-1:0]      dd;
    logic [2*W-1:0]      t;
    logic signed [W-1:0] sd;
    dd = {d, d};
    sd = d;
    case (m)
      0: begin t = dd >> a; return t[W-1:0]; end
      1: begin t = dd << a; return t[2*W-1:W]; end
      2: return d >> a;
      default: return sd >>> a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else n_pass++;
    n_checks++; if (out_zero !== 1'b1) $display("FAIL reset_out_zero got %b exp 1", out_zero); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    tick();
  endtask

  // Directed back-to-back vectors with cycle-exact latency checks.
  task automatic run_vectors(input string name, input logic [W-1:0] d[], input int a[],
                             input int m[], input logic [W-1:0] e[]);
    int n;
    n = d.size();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < n + LAT + 1; cyc++) begin
      if (cyc < n) begin
        in_valid = 1'b1; in_data = d[cyc]; in_amt = 3'(a[cyc]); in_mode = 2'(m[cyc]);
      end else begin
        in_valid = 1'b0; in_data = $urandom; in_amt = '0; in_mode = '0;
      end
      #1;
      if (cyc >= LAT && cyc - LAT < n) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s_valid[%0d] got %b exp 1", name, cyc - LAT, out_valid); else n_pass++;
        n_checks++;
        if (out_data !== e[cyc-LAT]) $display("FAIL %s_data[%0d] got %h exp %h", name, cyc - LAT, out_data, e[cyc-LAT]); else n_pass++;
        n_checks++;
        if (out_zero !== (e[cyc-LAT] == 0)) $display("FAIL %s_zero[%0d] got %b exp %b", name, cyc - LAT, out_zero, e[cyc-LAT] == 0); else n_pass++;
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL %s_idle_valid[%0d] got %b exp 0", name, cyc, out_valid); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_modes();
    logic [W-1:0] d[]; int a[]; int m[]; logic [W-1:0] e[];
    d = '{8'hB4, 8'hB4, 8'hB4, 8'hB4};
    a = '{3, 3, 3, 3};
    m = '{0, 1, 2, 3};
    e = '{8'h96, 8'hA5, 8'h16, 8'hF6};
    run_vectors("modes", d, a, m, e);
  endtask

  task automatic test_extremes();
    logic [W-1:0] d[]; int a[]; int m[]; logic [W-1:0] e[];
    d = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'h80};
    a = '{0, 0, 0, 0, 7, 7, 1, 7, 7};
    m = '{0, 1, 2, 3, 2, 3, 2, 0, 1};
    e = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h40};
    run_vectors("extremes", d, a, m, e);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
    int a, m;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom); a = $urandom_range(7); m = $urandom_range(3);
      exp_q.push_back(ref_shift(d, a, m));
      in_valid = 1'b1; in_data = d; in_amt = 3'(a); in_mode = 2'(m);
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1; in_data = 8'hAA; in_amt = 3'd1; in_mode = 2'd0; out_ready = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", s, in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b exp 1", s, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_q[0]) $display("FAIL bp_hold_data[%0d] got %h exp %h", s, out_data, exp_q[0]); else n_pass++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d] got %b exp 1", j, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_q[j]) $display("FAIL bp_drain_data[%0d] got %h exp %h", j, out_data, exp_q[j]); else n_pass++;
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_after_drain_valid got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int n_in, n_out;
    n_in = 0; n_out = 0;
    for (int cyc = 0; cyc < 640; cyc++) begin
      if (cyc < 600) begin
        in_valid  = ($urandom_range(99) < 65);
        out_ready = ($urandom_range(99) < 70);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      in_data = W'($urandom); in_amt = 3'($urandom_range(7)); in_mode = 2'($urandom_range(3));
      #1;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL rnd_in_ready[%0d] got %b exp %b", cyc, in_ready, !(out_valid && !out_ready));
      else n_pass++;
      if (out_valid === 1'b1 && out_ready) begin
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_unexpected_beat[%0d] got %h exp none", cyc, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_zero !== (e == 0))
            $display("FAIL rnd_data[%0d] got %h/z%b exp %h/z%b", cyc, out_data, out_zero, e, e == 0);
          else n_pass++;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        n_in++;
        exp_q.push_back(ref_shift(in_data, int'(in_amt), int'(in_mode)));
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_leftover got %0d exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (n_out != n_in) $display("FAIL rnd_beat_count got %0d exp %0d", n_out, n_in); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    logic [W-1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = W'($urandom | 1); in_amt = 3'($urandom_range(7)); in_mode = 2'($urandom_range(3));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_stalled_valid got %b exp 1", out_valid); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_zero !== 1'b1) $display("FAIL rstmid_zero got %b exp 1", out_zero); else n_pass++;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_stale[%0d] got %b exp 0", c, out_valid); else n_pass++;
      tick();
    end
    d = W'($urandom); e = ref_shift(d, 5, 3);
    in_valid = 1'b1; in_data = d; in_amt = 3'd5; in_mode = 2'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== e) $display("FAIL rstmid_recover got %b/%h exp 1/%h", out_valid, out_data, e);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_extremes();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
